// File: rtl/md_unit.sv
// md_unit - multi-cycle multiply/divide unit for the EX stage.
//
// Owns the HI/LO architectural registers and executes mult, multu, div,
// divu, mthi and mtlo. A multiply holds busy for MUL_CYCLES cycles and then
// writes the 64-bit product to {HI,LO}. A divide runs DIV_ITERS restoring
// shift/subtract steps, then one sign-fixup cycle, and writes the quotient
// to LO and the remainder to HI. md_signal tells the ID-stage hazard unit
// to hold dependent instructions; it also covers the cycle a multiply or
// divide is issued, before busy has risen.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   start      in   1   md instruction valid in EX this cycle
//   md_op      in   3   000 mult, 001 multu, 010 div, 011 divu,
//                       100 mthi, 101 mtlo, others no-op
//   src_a      in  32   rs value (dividend / multiplicand / mthi-mtlo data)
//   src_b      in  32   rt value (divisor / multiplier)
//   flush      in   1   cancel any in-flight operation, no HI/LO write
//   busy       out  1   operation in progress
//   md_signal  out  1   stall request to the hazard unit
//   hi         out 32   HI register
//   lo         out 32   LO register
module md_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        md_signal,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;     // multiplicand, or quotient while dividing
  logic [31:0]        b_q, b_d;     // multiplier, or |divisor|
  logic [31:0]        rem_q, rem_d;
  logic               sgn_q, sgn_d; // signed operation
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic signed [63:0] mul_a, mul_b, prod;
  logic [32:0]        rem_sh, diff;

  // Two's-complement negate when en is set; used for |x| and sign fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  // Sign-extend (signed op) or zero-extend both operands to 64 bits so that
  // the low 64 bits of a 64x64 multiply are the exact 32x32 product.
  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // Restoring step: shift next dividend bit into the partial remainder and
  // try subtracting the divisor; bit 32 of diff set means it did not fit.
  assign rem_sh = {rem_q, a_q[31]};
  assign diff   = rem_sh - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            case (md_op)
              3'b000, 3'b001: begin
                a_d     = src_a;
                b_d     = src_b;
                sgn_d   = ~md_op[0];
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
                state_d = S_MUL;
              end
              3'b010, 3'b011: begin
                sgn_d   = ~md_op[0];
                a_d     = neg_if(src_a, ~md_op[0] & src_a[31]);
                b_d     = neg_if(src_b, ~md_op[0] & src_b[31]);
                qneg_d  = ~md_op[0] & (src_a[31] ^ src_b[31]);
                rneg_d  = ~md_op[0] & src_a[31];
                rem_d   = 32'd0;
                cnt_d   = CNT_W'(DIV_ITERS - 1);
                state_d = S_DIV;
              end
              3'b100:  hi_d = src_a;
              3'b101:  lo_d = src_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (!diff[32]) begin
            rem_d = diff[31:0];
            a_d   = {a_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            a_d   = {a_q[30:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          // Divide by zero leaves HI/LO untouched but keeps the same latency.
          if (b_q != 32'd0) begin
            lo_d = neg_if(a_q, qneg_q);
            hi_d = neg_if(rem_q, rneg_q);
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign md_signal = busy | (start & ~md_op[2] & (state_q == S_IDLE));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        md_signal;
  logic [31:0] hi;
  logic [31:0] lo;

  int vecs = 0;
  int errs = 0;

  md_unit #(.MUL_CYCLES(4), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .md_signal(md_signal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present an op in the current cycle; caller advances the clock.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles busy stays high, bounded so a stuck unit cannot hang.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; md_op = 3'b000; src_a = '0; src_b = '0; flush = 1'b0;
    #2;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_signal !== 1'b0) begin
      errs++;
      $display("FAIL reset: busy=%b md=%b hi=%h lo=%h, want 0 0 0 0", busy, md_signal, hi, lo);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_multu();
    int n;
    drive(3'b001, 32'hFFFF_FFFF, 32'd2);
    #1;
    vecs++;
    if (md_signal !== 1'b1) begin
      errs++; $display("FAIL multu_md_signal: got %b want 1", md_signal);
    end
    step();
    start = 1'b0;
    wait_idle(n);
    vecs++;
    if (n != 4) begin
      errs++; $display("FAIL multu_busy_cycles: got %0d want 4", n);
    end
    vecs++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      errs++; $display("FAIL multu_result: hi=%h lo=%h want 00000001 fffffffe", hi, lo);
    end
  endtask

  task automatic test_mult_mthi();
    int n;
    issue(3'b000, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    vecs++;
    if (n != 4 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errs++; $display("FAIL mult_signed: n=%0d hi=%h lo=%h want 4 ffffffff fffffff1", n, hi, lo);
    end
    drive(3'b100, 32'h0000_1234, 32'd0);
    #1;
    vecs++;
    if (md_signal !== 1'b0) begin
      errs++; $display("FAIL mthi_md_signal: got %b want 0", md_signal);
    end
    step();
    start = 1'b0;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFF1) begin
      errs++; $display("FAIL mthi: busy=%b hi=%h lo=%h want 0 00001234 fffffff1", busy, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    vecs++;
    if (n != 33) begin
      errs++; $display("FAIL div_busy_cycles: got %0d want 33", n);
    end
    vecs++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL div_signed: lo=%h hi=%h want fffffffd ffffffff", lo, hi);
    end
    issue(3'b011, 32'd100, 32'd7);
    wait_idle(n);
    vecs++;
    if (n != 33 || lo !== 32'd14 || hi !== 32'd2) begin
      errs++; $display("FAIL divu: n=%0d lo=%0d hi=%0d want 33 14 2", n, lo, hi);
    end
    // Most-negative / -1 wraps rather than trapping.
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    vecs++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errs++; $display("FAIL div_overflow: lo=%h hi=%h want 80000000 00000000", lo, hi);
    end
    // Negative dividend, positive quotient: -20 / -6 = 3 rem -2.
    issue(3'b010, 32'hFFFF_FFEC, 32'hFFFF_FFFA);
    wait_idle(n);
    vecs++;
    if (lo !== 32'd3 || hi !== 32'hFFFF_FFFE) begin
      errs++; $display("FAIL div_negneg: lo=%h hi=%h want 00000003 fffffffe", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'b100, 32'h0000_AAAA, 32'd0);
    issue(3'b101, 32'h0000_5555, 32'd0);
    issue(3'b011, 32'd1234, 32'd0);
    wait_idle(n);
    vecs++;
    if (n != 33 || busy !== 1'b0 || hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      errs++; $display("FAIL div_zero: n=%0d busy=%b hi=%h lo=%h want 33 0 0000aaaa 00005555", n, busy, hi, lo);
    end
  endtask

  task automatic test_flush();
    int n;
    issue(3'b100, 32'h0000_1111, 32'd0);
    issue(3'b101, 32'h0000_2222, 32'd0);
    issue(3'b010, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) begin
      if (i == 5) drive(3'b000, 32'd3, 32'd3);
      step();
      start = 1'b0;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL flush_busy: got %b want 0", busy);
    end
    for (int i = 0; i < 40; i++) step();
    vecs++;
    if (hi !== 32'h0000_1111 || lo !== 32'h0000_2222) begin
      errs++; $display("FAIL flush_hilo: hi=%h lo=%h want 00001111 00002222", hi, lo);
    end
    // flush wins over a same-cycle mthi
    drive(3'b100, 32'h0000_DEAD, 32'd0);
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    vecs++;
    if (hi !== 32'h0000_1111 || busy !== 1'b0) begin
      errs++; $display("FAIL flush_mthi: hi=%h busy=%b want 00001111 0", hi, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'b011, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 200) begin
      if (n == 5) drive(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      start = 1'b0;
      n++;
    end
    vecs++;
    if (n != 33 || lo !== 32'd14 || hi !== 32'd2) begin
      errs++; $display("FAIL start_while_busy: n=%0d lo=%0d hi=%0d want 33 14 2", n, lo, hi);
    end
  endtask

  task automatic test_async_reset();
    issue(3'b100, 32'h0000_0005, 32'd0);
    issue(3'b101, 32'h0000_0006, 32'd0);
    issue(3'b000, 32'd9, 32'd9);
    step();
    #3;
    rst = 1'b1;
    #1;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL async_reset: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    step();
    rst = 1'b0;
    step();
    issue(3'b101, 32'h0000_0077, 32'd0);
    vecs++;
    if (lo !== 32'h0000_0077 || hi !== 32'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL mtlo_after_reset: lo=%h hi=%h busy=%b want 00000077 0 0", lo, hi, busy);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_mthi();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu/mthi/mtlo.
- Drives md_signal to the ID-stage hazard/forwarding unit, which stalls dependent mfhi/mflo and further md ops while it is high.

Parameters:
- MUL_CYCLES, 4, cycles busy is high for mult/multu (>=1).
- DIV_ITERS, 32, restoring-division iteration count (fixed at the data width; not to be changed).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  EX-stage md instruction valid this cycle
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
- src_a  input  32  rs value (dividend / multiplicand / mthi-mtlo source)
- src_b  input  32  rt value (divisor / multiplier)
- flush  input  1  cancel in-flight op (exception/eret), synchronous
- busy  output  1  operation in progress
- md_signal  output  1  busy | (start & md_op in {000..011} & state==IDLE); combinational
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, hi=0, lo=0, counter=0, internal operands cleared. Reset mid-operation aborts the operation with no HI/LO write.
- FSM states: IDLE, MUL, DIV, DIV_FIX.
- IDLE with start=1 and flush=0:
  - mthi/mtlo: HI (resp. LO) <= src_a at that edge. Stay IDLE, busy stays 0.
  - mult/multu: latch operands, counter <= MUL_CYCLES-1, go to MUL.
  - div/divu: latch |a|,|b| (signed) or raw (unsigned), record quotient sign (a[31]^b[31]) and remainder sign (a[31]) for signed ops, counter <= DIV_ITERS-1, go to DIV.
  - Undefined md_op: ignored.
- MUL: busy=1. Decrement each edge. At the edge where counter==0: {hi,lo} <= 64-bit product (signed for mult, unsigned for multu), go to IDLE. busy is high for exactly MUL_CYCLES cycles.
- DIV: busy=1. One restoring shift/subtract step per edge, DIV_ITERS edges, then go to DIV_FIX.
- DIV_FIX: busy=1. Apply signs: lo=quotient, hi=remainder; quotient truncates toward zero, remainder takes the dividend's sign. Write HI/LO at the end of this cycle and go to IDLE. Total busy = 33 cycles.
- Divide by zero (b latched ==0): same 33-cycle latency, HI/LO left unchanged.
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0 (wrap, no trap).
- start while busy: ignored; the hazard unit guarantees it never occurs.
- flush=1 (any state): return to IDLE at the next edge with no HI/LO write. flush with start in the same cycle: start ignored, including mthi/mtlo.
- hi/lo outputs are the register values. The new result is visible the cycle after busy falls.
- No forwarding of in-flight results; consumers wait on md_signal.

Test Plan:
- multu a=0xFFFFFFFF b=2 -> busy high exactly 4 cycles, then hi=0x00000001, lo=0xFFFFFFFE; md_signal high in the start cycle.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; mthi 0x1234 next cycle -> hi=0x00001234, busy never set.
- div a=0xFFFFFFF9 (-7) b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100 b=7 -> lo=14, hi=2.
- divu b=0 with hi=0xAAAA lo=0x5555 preloaded -> after 33 cycles hi/lo unchanged, busy=0.
- div started, flush at cycle 10 -> busy=0 next cycle, hi/lo unchanged; start asserted during busy ignored (no result change).
- rst asserted asynchronously mid-mult (between clock edges) -> busy, hi, lo=0 immediately; after release, mtlo 0x77 -> lo=0x77.
